// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - control/datapath signal bundle for the multicycle ARM controller
interface mc_controller_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic       Illegal;

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, Illegal
    );

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, Illegal
    );
endinterface

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM control FSM with NZCV flags and condition-gated writes
module mc_controller #(
    parameter logic [3:0] PC_REG       = 4'hF,
    parameter bit         ILLEGAL_TRAP = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    mc_controller_if.slave bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_UNKNOWN
    } state_t;

    state_t     r_state;
    state_t     w_next;
    state_t     w_state_d;
    logic [3:0] r_flags;
    logic       r_next_pc, r_reg_w, r_mem_w, r_branch, r_alu_op;
    logic       r_ir_write, r_adr_src, r_alu_src_a, r_illegal;
    logic [1:0] r_alu_src_b, r_result_src;
    logic       w_cmd_ok, w_cmd_arith, w_cond_ex, w_pcs, w_rd_is_pc, w_ge;
    logic [1:0] w_alu_ctl, w_flag_w;

    always_comb begin
        w_cmd_ok    = 1'b1;
        w_cmd_arith = 1'b0;
        w_alu_ctl   = 2'b00;
        case (bus.Funct[4:1])
            4'b0100: begin w_alu_ctl = 2'b00; w_cmd_arith = 1'b1; end
            4'b0010: begin w_alu_ctl = 2'b01; w_cmd_arith = 1'b1; end
            4'b0000: w_alu_ctl = 2'b10;
            4'b1100: w_alu_ctl = 2'b11;
            default: w_cmd_ok = 1'b0;
        endcase
    end

    // Condition is evaluated against the committed flags, never the live ALU flags.
    assign w_ge = (r_flags[3] == r_flags[0]);
    always_comb begin
        w_cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: w_cond_ex = r_flags[2];
            4'b0001: w_cond_ex = ~r_flags[2];
            4'b0010: w_cond_ex = r_flags[1];
            4'b0011: w_cond_ex = ~r_flags[1];
            4'b0100: w_cond_ex = r_flags[3];
            4'b0101: w_cond_ex = ~r_flags[3];
            4'b0110: w_cond_ex = r_flags[0];
            4'b0111: w_cond_ex = ~r_flags[0];
            4'b1000: w_cond_ex = r_flags[1] & ~r_flags[2];
            4'b1001: w_cond_ex = ~(r_flags[1] & ~r_flags[2]);
            4'b1010: w_cond_ex = w_ge;
            4'b1011: w_cond_ex = ~w_ge;
            4'b1100: w_cond_ex = ~r_flags[2] & w_ge;
            4'b1101: w_cond_ex = ~(~r_flags[2] & w_ge);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (bus.Op == 2'b01)      w_next = S_MEMADR;
                else if (bus.Op == 2'b00) w_next = bus.Funct[5] ? S_EXECI : S_EXECR;
                else if (bus.Op == 2'b10) w_next = S_BRANCH;
                else                      w_next = S_UNKNOWN;
            end
            S_MEMADR:  w_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = S_MEMWB;
            S_EXECR,
            S_EXECI:   w_next = w_cmd_ok ? S_ALUWB : S_UNKNOWN;
            S_UNKNOWN: w_next = ILLEGAL_TRAP ? S_UNKNOWN : S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    assign w_state_d = reset ? S_FETCH : w_next;
    assign w_flag_w[1] = r_alu_op & bus.Funct[0];
    assign w_flag_w[0] = w_flag_w[1] & w_cmd_arith;

    // Control bits are registered from the upcoming state so they line up with it.
    always_ff @(posedge clk) begin
        r_state      <= w_state_d;
        r_next_pc    <= 1'b0;
        r_reg_w      <= 1'b0;
        r_mem_w      <= 1'b0;
        r_branch     <= 1'b0;
        r_alu_op     <= 1'b0;
        r_ir_write   <= 1'b0;
        r_adr_src    <= 1'b0;
        r_alu_src_a  <= 1'b0;
        r_illegal    <= 1'b0;
        r_alu_src_b  <= 2'b00;
        r_result_src <= 2'b00;
        case (w_state_d)
            S_FETCH: begin
                r_ir_write <= 1'b1; r_next_pc <= 1'b1; r_alu_src_a <= 1'b1;
                r_alu_src_b <= 2'b10; r_result_src <= 2'b10;
            end
            S_DECODE: begin
                r_alu_src_a <= 1'b1; r_alu_src_b <= 2'b10; r_result_src <= 2'b10;
            end
            S_MEMADR: r_alu_src_b <= 2'b01;
            S_MEMRD:  r_adr_src <= 1'b1;
            S_MEMWB:  begin r_result_src <= 2'b01; r_reg_w <= 1'b1; end
            S_MEMWR:  begin r_adr_src <= 1'b1; r_mem_w <= 1'b1; end
            S_EXECR:  r_alu_op <= 1'b1;
            S_EXECI:  begin r_alu_src_b <= 2'b01; r_alu_op <= 1'b1; end
            S_ALUWB:  r_reg_w <= 1'b1;
            S_BRANCH: begin
                r_alu_src_b <= 2'b01; r_result_src <= 2'b10; r_branch <= 1'b1;
            end
            S_UNKNOWN: r_illegal <= 1'b1;
            default:   r_illegal <= 1'b0;
        endcase

        if (reset) begin
            r_flags <= 4'b0000;
        end else if ((r_state == S_EXECR || r_state == S_EXECI) && w_cond_ex) begin
            if (w_flag_w[1]) r_flags[3:2] <= bus.ALUFlags[3:2];
            if (w_flag_w[0]) r_flags[1:0] <= bus.ALUFlags[1:0];
        end
    end

    assign w_rd_is_pc     = (bus.Rd == PC_REG);
    assign w_pcs          = r_branch | (r_reg_w & w_rd_is_pc);
    assign bus.PCWrite    = ~reset & (r_next_pc | (w_pcs & w_cond_ex));
    assign bus.RegWrite   = ~reset & r_reg_w & w_cond_ex & ~w_rd_is_pc;
    assign bus.MemWrite   = ~reset & r_mem_w & w_cond_ex;
    assign bus.IRWrite    = ~reset & r_ir_write;
    assign bus.AdrSrc     = r_adr_src;
    assign bus.ALUSrcA    = r_alu_src_a;
    assign bus.ALUSrcB    = r_alu_src_b;
    assign bus.ResultSrc  = r_result_src;
    assign bus.ALUControl = r_alu_op ? w_alu_ctl : 2'b00;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.Illegal    = r_illegal;
endmodule
